exc_flow_ctrl: RTL and testbench

Exception/interrupt sequencer for the five-stage MIPS pipeline. It evaluates exceptions and interrupts at the M-stage commit point and raises a one-cycle `req` that flushes the pipeline and redirects fetch to the handler. It owns SR/Cause/EPC/PRId, serves mfc0/mtc0, and drives the EPC consumed by the fetch unit on `eret`.

---
 rtl/exc_defs.sv | 31 +++
 rtl/exc_prio_enc.sv | 21 ++
 rtl/exc_flow_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_flow_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_defs.sv
// Shared CP0 definitions for the exception sequencer: register numbers, ExcCodes,
// SR/Cause field positions, handler entry and the RUN/HANDLER state type.
package exc_defs;

  localparam logic [4:0] Cp0Sr    = 5'd12;
  localparam logic [4:0] Cp0Cause = 5'd13;
  localparam logic [4:0] Cp0Epc   = 5'd14;
  localparam logic [4:0] Cp0Prid  = 5'd15;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  localparam int unsigned SrIeBit      = 0;
  localparam int unsigned SrExlBit     = 1;
  localparam int unsigned SrImLsb      = 10;
  localparam int unsigned SrImMsb      = 15;
  localparam int unsigned CauseCodeLsb = 2;
  localparam int unsigned CauseCodeMsb = 6;
  localparam int unsigned CauseIpLsb   = 10;
  localparam int unsigned CauseIpMsb   = 15;
  localparam int unsigned CauseBdBit   = 31;

  localparam logic [31:0] HandlerPcDefault = 32'h0000_4180;
  localparam logic [31:0] PridValDefault   = 32'h2021_0001;

  typedef enum logic {StRun, StHandler} exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Decides whether an exception is taken this cycle; an interrupt beats a
// synchronous exception and reports ExcCode 0.
module exc_prio_enc
  import exc_defs::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] sr_im,
  input  logic       sr_ie,
  input  logic       sr_exl,
  input  logic       m_exc_valid,
  input  logic [4:0] m_exc_code,
  output logic       take,
  output logic [4:0] code,
  output logic       is_int
);

  assign is_int = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign take   = is_int | m_exc_valid;
  assign code   = is_int ? ExcInt : m_exc_code;

endmodule

// File: rtl/exc_flow_ctrl.sv
// Exception/interrupt sequencer at the M-stage commit point; owns SR/Cause/EPC/PRId.
// Define EXC_BD_EN to record branch-delay-slot faults (EPC = m_pc - 4, Cause.BD = 1).
module exc_flow_ctrl
  import exc_defs::*;
#(
  parameter logic [31:0] HANDLER_PC = HandlerPcDefault,
  parameter logic [31:0] PRID_VAL   = PridValDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic [31:0] m_pc,
  input  logic        m_exc_valid,
  input  logic [4:0]  m_exc_code,
  input  logic        m_bd,
  input  logic        m_mtc0,
  input  logic [4:0]  m_cp0_addr,
  input  logic [31:0] m_cp0_wdata,
  input  logic        d_eret,
  output logic [31:0] cp0_rdata,
  output logic        req,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_out,
  output logic        exl
);

  exc_state_e  state_q;
  logic [5:0]  sr_im_q;
  logic        sr_ie_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_code_q;
  logic [31:0] epc_q;

  logic        take;
  logic        is_int;
  logic [4:0]  code;
  logic [4:0]  code_new;
  logic [31:0] epc_new;
  logic        bd_new;
  logic        mtc0_epc;

  assign exl = (state_q == StHandler);

  exc_prio_enc u_prio (
    .hw_int      (hw_int),
    .sr_im       (sr_im_q),
    .sr_ie       (sr_ie_q),
    .sr_exl      (exl),
    .m_exc_valid (m_exc_valid),
    .m_exc_code  (m_exc_code),
    .take        (take),
    .code        (code),
    .is_int      (is_int)
  );

  assign req         = take & ~reset;
  assign redirect_pc = HANDLER_PC;
  assign code_new    = is_int ? ExcInt : code;

`ifdef EXC_BD_EN
  assign epc_new = m_bd ? (m_pc - 32'd4) : m_pc;
  assign bd_new  = m_bd;
`else
  logic unused_m_bd;
  assign unused_m_bd = m_bd;
  assign epc_new     = m_pc;
  assign bd_new      = 1'b0;
`endif

  // Bypass lets an eret in D see an EPC that is being written by mtc0 in M.
  assign mtc0_epc = m_mtc0 & (m_cp0_addr == Cp0Epc);
  assign epc_out  = mtc0_epc ? m_cp0_wdata : epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      sr_im_q      <= '0;
      sr_ie_q      <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_ip_q   <= '0;
      cause_code_q <= '0;
      epc_q        <= '0;
    end else begin
      cause_ip_q <= hw_int;
      if (req) begin
        // A nested exception keeps the original EPC/BD so the first handler can return.
        cause_code_q <= code_new;
        state_q      <= StHandler;
        if (state_q == StRun) begin
          epc_q      <= epc_new;
          cause_bd_q <= bd_new;
        end
      end else begin
        if (m_mtc0) begin
          case (m_cp0_addr)
            Cp0Sr: begin
              sr_im_q <= m_cp0_wdata[SrImMsb:SrImLsb];
              sr_ie_q <= m_cp0_wdata[SrIeBit];
              state_q <= m_cp0_wdata[SrExlBit] ? StHandler : StRun;
            end
            Cp0Cause: cause_code_q <= m_cp0_wdata[CauseCodeMsb:CauseCodeLsb];
            Cp0Epc:   epc_q        <= m_cp0_wdata;
            default:  ;
          endcase
        end
        if (d_eret && (state_q == StHandler)) begin
          state_q <= StRun;
        end
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (m_cp0_addr)
      Cp0Sr: begin
        cp0_rdata[SrImMsb:SrImLsb] = sr_im_q;
        cp0_rdata[SrExlBit]        = exl;
        cp0_rdata[SrIeBit]         = sr_ie_q;
      end
      Cp0Cause: begin
        cp0_rdata[CauseBdBit]                = cause_bd_q;
        cp0_rdata[CauseIpMsb:CauseIpLsb]     = cause_ip_q;
        cp0_rdata[CauseCodeMsb:CauseCodeLsb] = cause_code_q;
      end
      Cp0Epc:  cp0_rdata = epc_q;
      Cp0Prid: cp0_rdata = PRID_VAL;
      default: cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_flow_ctrl.sv
// Self-checking bench for exc_flow_ctrl: directed scenarios plus a randomized run
// against a register-level reference model.
`timescale 1ns / 1ps
module tb_exc_flow_ctrl;

  localparam logic [31:0] Handler = 32'h0000_4180;
  localparam logic [31:0] Prid    = 32'h2021_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [31:0] m_pc;
  logic        m_exc_valid;
  logic [4:0]  m_exc_code;
  logic        m_bd;
  logic        m_mtc0;
  logic [4:0]  m_cp0_addr;
  logic [31:0] m_cp0_wdata;
  logic        d_eret;
  logic [31:0] cp0_rdata;
  logic        req;
  logic [31:0] redirect_pc;
  logic [31:0] epc_out;
  logic        exl;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural register images.
  logic [31:0] mdl_sr = '0;
  logic [31:0] mdl_cause = '0;
  logic [31:0] mdl_epc = '0;

  exc_flow_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hw_int      (hw_int),
    .m_pc        (m_pc),
    .m_exc_valid (m_exc_valid),
    .m_exc_code  (m_exc_code),
    .m_bd        (m_bd),
    .m_mtc0      (m_mtc0),
    .m_cp0_addr  (m_cp0_addr),
    .m_cp0_wdata (m_cp0_wdata),
    .d_eret      (d_eret),
    .cp0_rdata   (cp0_rdata),
    .req         (req),
    .redirect_pc (redirect_pc),
    .epc_out     (epc_out),
    .exl         (exl)
  );

  always #10 clk = ~clk;

  function automatic logic mdl_int();
    return ((hw_int & mdl_sr[15:10]) != 6'd0) && mdl_sr[0] && !mdl_sr[1];
  endfunction

  function automatic logic mdl_req();
    return !reset && (mdl_int() || m_exc_valid);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    case (a)
      5'd12:   return mdl_sr;
      5'd13:   return mdl_cause;
      5'd14:   return mdl_epc;
      5'd15:   return Prid;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_epc_out();
    return (m_mtc0 && m_cp0_addr == 5'd14) ? m_cp0_wdata : mdl_epc;
  endfunction

  task automatic model_step();
    logic [31:0] sr_n, ca_n, epc_n;
    sr_n  = mdl_sr;
    ca_n  = mdl_cause;
    epc_n = mdl_epc;
    if (reset) begin
      sr_n = 0; ca_n = 0; epc_n = 0;
    end else begin
      ca_n[15:10] = hw_int;
      if (mdl_req()) begin
        ca_n[6:2] = mdl_int() ? 5'd0 : m_exc_code;
        if (!mdl_sr[1]) begin
`ifdef EXC_BD_EN
          epc_n    = m_bd ? m_pc - 32'd4 : m_pc;
          ca_n[31] = m_bd;
`else
          epc_n    = m_pc;
          ca_n[31] = 1'b0;
`endif
        end
        sr_n[1] = 1'b1;
      end else begin
        if (m_mtc0) begin
          if (m_cp0_addr == 5'd12) sr_n = m_cp0_wdata & 32'h0000_FC03;
          if (m_cp0_addr == 5'd13) ca_n[6:2] = m_cp0_wdata[6:2];
          if (m_cp0_addr == 5'd14) epc_n = m_cp0_wdata;
        end
        if (d_eret && mdl_sr[1]) sr_n[1] = 1'b0;
      end
    end
    mdl_sr    = sr_n;
    mdl_cause = ca_n;
    mdl_epc   = epc_n;
  endtask

  task automatic idle();
    hw_int = 0; m_pc = 0; m_exc_valid = 0; m_exc_code = 0; m_bd = 0;
    m_mtc0 = 0; m_cp0_addr = 0; m_cp0_wdata = 0; d_eret = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL reset_exl: got %b want 0", exl); end
    checks++; if (epc_out !== 32'd0) begin errors++; $display("FAIL reset_epc_out: got %h want 0", epc_out); end
    checks++; if (redirect_pc !== Handler) begin errors++; $display("FAIL redirect_pc: got %h want %h", redirect_pc, Handler); end
    for (int a = 11; a <= 16; a++) begin
      m_cp0_addr = 5'(a);
      exp = (a == 15) ? Prid : 32'd0;
      #1;
      checks++; if (cp0_rdata !== exp) begin errors++; $display("FAIL reset_cp0_%0d: got %h want %h", a, cp0_rdata, exp); end
    end
  endtask

  task automatic test_adel();
    idle(); m_pc = 32'h3004; m_exc_valid = 1; m_exc_code = 5'd4; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL adel_req: got %b want 1", req); end
    tick(); idle(); #1;
    checks++; if (exl !== 1'b1) begin errors++; $display("FAIL adel_exl: got %b want 1", exl); end
    m_cp0_addr = 5'd14; #1;
    checks++; if (cp0_rdata !== 32'h3004) begin errors++; $display("FAIL adel_epc: got %h want 3004", cp0_rdata); end
    m_cp0_addr = 5'd13; #1;
    checks++; if (cp0_rdata[6:2] !== 5'd4) begin errors++; $display("FAIL adel_code: got %0d want 4", cp0_rdata[6:2]); end
    idle(); d_eret = 1; tick(); idle(); #1;
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL adel_eret: got %b want 0", exl); end
  endtask

  task automatic test_interrupt();
    idle(); m_mtc0 = 1; m_cp0_addr = 5'd12; m_cp0_wdata = 32'h0000_0401; tick(); idle();
    hw_int = 6'h01; m_pc = 32'h3010; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL int_req: got %b want 1", req); end
    tick(); idle(); hw_int = 6'h01; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL int_masked_exl: got %b want 0", req); end
    m_cp0_addr = 5'd13; #1;
    checks++; if (cp0_rdata[6:2] !== 5'd0) begin errors++; $display("FAIL int_code: got %0d want 0", cp0_rdata[6:2]); end
    m_cp0_addr = 5'd14; #1;
    checks++; if (cp0_rdata !== 32'h3010) begin errors++; $display("FAIL int_epc: got %h want 3010", cp0_rdata); end
    idle(); d_eret = 1; tick();
    idle(); m_mtc0 = 1; m_cp0_addr = 5'd12; m_cp0_wdata = 32'h0000_0400; tick();
    idle(); hw_int = 6'h01; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL int_masked_ie: got %b want 0", req); end
    idle();
  endtask

  task automatic test_bd();
    logic [31:0] exp_epc;
    logic        exp_bd;
`ifdef EXC_BD_EN
    exp_epc = 32'h301C; exp_bd = 1'b1;
`else
    exp_epc = 32'h3020; exp_bd = 1'b0;
`endif
    idle(); m_pc = 32'h3020; m_exc_valid = 1; m_exc_code = 5'd12; m_bd = 1; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL bd_req: got %b want 1", req); end
    tick(); idle(); m_cp0_addr = 5'd14; #1;
    checks++; if (cp0_rdata !== exp_epc) begin errors++; $display("FAIL bd_epc: got %h want %h", cp0_rdata, exp_epc); end
    m_cp0_addr = 5'd13; #1;
    checks++; if (cp0_rdata[31] !== exp_bd) begin errors++; $display("FAIL bd_bit: got %b want %b", cp0_rdata[31], exp_bd); end
    idle(); d_eret = 1; tick(); idle();
  endtask

  task automatic test_eret_bypass();
    idle(); m_pc = 32'h3040; m_exc_valid = 1; m_exc_code = 5'd10; tick();
    idle(); m_mtc0 = 1; m_cp0_addr = 5'd14; m_cp0_wdata = 32'h3100; d_eret = 1; #1;
    checks++; if (epc_out !== 32'h3100) begin errors++; $display("FAIL bypass_epc_out: got %h want 3100", epc_out); end
    checks++; if (exl !== 1'b1) begin errors++; $display("FAIL bypass_exl_before: got %b want 1", exl); end
    tick(); idle(); #1;
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL bypass_exl_after: got %b want 0", exl); end
    checks++; if (epc_out !== 32'h3100) begin errors++; $display("FAIL bypass_epc_reg: got %h want 3100", epc_out); end
  endtask

  task automatic test_priority_nested();
    idle(); m_mtc0 = 1; m_cp0_addr = 5'd12; m_cp0_wdata = 32'h0000_0401; tick();
    idle(); hw_int = 6'h01; m_exc_valid = 1; m_exc_code = 5'd10; m_pc = 32'h3200; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", req); end
    tick(); idle(); m_cp0_addr = 5'd13; #1;
    checks++; if (cp0_rdata[6:2] !== 5'd0) begin errors++; $display("FAIL prio_code: got %0d want 0", cp0_rdata[6:2]); end
    idle(); m_exc_valid = 1; m_exc_code = 5'd10; m_pc = 32'h3300; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL nested_req: got %b want 1", req); end
    tick(); idle(); m_cp0_addr = 5'd14; #1;
    checks++; if (cp0_rdata !== 32'h3200) begin errors++; $display("FAIL nested_epc: got %h want 3200", cp0_rdata); end
    m_cp0_addr = 5'd13; #1;
    checks++; if (cp0_rdata[6:2] !== 5'd10) begin errors++; $display("FAIL nested_code: got %0d want 10", cp0_rdata[6:2]); end
  endtask

  task automatic test_eret_with_req();
    idle(); d_eret = 1; m_exc_valid = 1; m_exc_code = 5'd5; m_pc = 32'h3400; #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL eret_req_req: got %b want 1", req); end
    tick(); idle(); #1;
    checks++; if (exl !== 1'b1) begin errors++; $display("FAIL eret_req_exl: got %b want 1", exl); end
  endtask

  task automatic test_reset_mid();
    idle(); reset = 1; m_exc_valid = 1; hw_int = 6'h3F; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", req); end
    tick(); reset = 0; idle(); #1;
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL rst_mid_exl: got %b want 0", exl); end
    for (int a = 12; a <= 14; a++) begin
      m_cp0_addr = 5'(a); #1;
      checks++; if (cp0_rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_cp0_%0d: got %h want 0", a, cp0_rdata); end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      hw_int      = 6'($urandom);
      m_pc        = $urandom & 32'h0000_FFFC;
      m_exc_valid = ($urandom_range(0, 7) == 0);
      m_exc_code  = 5'($urandom);
      m_bd        = 1'($urandom);
      m_mtc0      = ($urandom_range(0, 3) == 0);
      m_cp0_addr  = 5'($urandom_range(10, 17));
      m_cp0_wdata = $urandom;
      d_eret      = ($urandom_range(0, 5) == 0);
      #1;
      checks++; if (req !== mdl_req()) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", i, req, mdl_req()); end
      checks++; if (exl !== mdl_sr[1]) begin errors++; $display("FAIL rnd_exl[%0d]: got %b want %b", i, exl, mdl_sr[1]); end
      exp = mdl_epc_out();
      checks++; if (epc_out !== exp) begin errors++; $display("FAIL rnd_epc_out[%0d]: got %h want %h", i, epc_out, exp); end
      exp = mdl_read(m_cp0_addr);
      checks++; if (cp0_rdata !== exp) begin errors++; $display("FAIL rnd_cp0[%0d] addr %0d: got %h want %h", i, m_cp0_addr, cp0_rdata, exp); end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_adel();
    test_interrupt();
    test_bd();
    test_eret_bypass();
    test_priority_nested();
    test_eret_with_req();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
